// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared debug UART constants and types
package uart_pkg;

  // Escape byte; the transmitter uses the same value.
  localparam logic [7:0] ESC = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - RX line synchroniser with falling-edge detect
module uart_rx_sync (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic RX_I,
  output logic rx_sync,
  output logic rx_fall
);

  logic meta;
  logic prev;

  // Two-flop synchroniser plus a history flop; idle-high line, so reset to 1.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      meta    <= 1'b1;
      rx_sync <= 1'b1;
      prev    <= 1'b1;
    end else begin
      meta    <= RX_I;
      rx_sync <= meta;
      prev    <= rx_sync;
    end
  end

  assign rx_fall = prev & ~rx_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 debug UART receiver with pause/resume escape filter
module uart_rx
  import uart_pkg::*;
#(
  parameter int         CLK_RATE  = 100_000_000,
  parameter int         BAUD_RATE = 115200,
  parameter logic [7:0] RESUME    = 8'h00
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       RX_I,
  output logic [7:0] DATA_O,
  output logic       RX_DONE_O,
  output logic       RX_BUSY_O,
  output logic       FRAME_ERR_O,
  output logic       PAUSE_O,
  output logic       ESC_DETECTED_O
);

  localparam int BIT_TICKS  = CLK_RATE / BAUD_RATE;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int CNT_W      = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;

  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BIT_TICKS - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_TICKS - 1);

  rx_state_t        state;
  logic [CNT_W-1:0] tick_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             esc_pending;
  logic             rx_sync;
  logic             rx_fall;

  uart_rx_sync u_sync (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .RX_I    (RX_I),
    .rx_sync (rx_sync),
    .rx_fall (rx_fall)
  );

  // Frame FSM, bit-centre sampling and escape filtering with registered strobes.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state          <= ST_IDLE;
      tick_cnt       <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      esc_pending    <= 1'b0;
      DATA_O         <= '0;
      RX_DONE_O      <= 1'b0;
      FRAME_ERR_O    <= 1'b0;
      ESC_DETECTED_O <= 1'b0;
      PAUSE_O        <= 1'b0;
    end else begin
      RX_DONE_O      <= 1'b0;
      FRAME_ERR_O    <= 1'b0;
      ESC_DETECTED_O <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_fall) begin
            tick_cnt <= HALF_RELOAD;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (tick_cnt == '0) begin
            if (!rx_sync) begin
              tick_cnt <= BIT_RELOAD;
              bit_idx  <= '0;
              state    <= ST_DATA;
            end else begin
              // Line back high at mid-start: treat as a glitch.
              state <= ST_IDLE;
            end
          end else begin
            tick_cnt <= tick_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (tick_cnt == '0) begin
            shreg    <= {rx_sync, shreg[7:1]};
            tick_cnt <= BIT_RELOAD;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (tick_cnt == '0) begin
            // Leave at mid-stop so a start edge half a bit later is caught.
            state <= ST_IDLE;
            if (!rx_sync) begin
              FRAME_ERR_O <= 1'b1;
            end else if (!esc_pending) begin
              if (shreg == ESC) begin
                esc_pending    <= 1'b1;
                PAUSE_O        <= 1'b1;
                ESC_DETECTED_O <= 1'b1;
              end else begin
                DATA_O    <= shreg;
                RX_DONE_O <= 1'b1;
              end
            end else begin
              esc_pending <= 1'b0;
              if (shreg == RESUME) begin
                PAUSE_O <= 1'b0;
              end else begin
                DATA_O    <= shreg;
                RX_DONE_O <= 1'b1;
              end
            end
          end else begin
            tick_cnt <= tick_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign RX_BUSY_O = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx at 16 clocks per bit
module tb_uart_rx;

  localparam int         TB_CLK  = 1_600_000;
  localparam int         TB_BAUD = 100_000;
  localparam int         BT      = 16;
  localparam logic [7:0] TB_ESC  = 8'h1B;

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b1;
  logic       RX_I  = 1'b1;
  logic [7:0] DATA_O;
  logic       RX_DONE_O;
  logic       RX_BUSY_O;
  logic       FRAME_ERR_O;
  logic       PAUSE_O;
  logic       ESC_DETECTED_O;

  int n_vec = 0;
  int n_bad = 0;

  int         n_done = 0;
  int         n_ferr = 0;
  int         n_esc  = 0;
  logic [7:0] dlog [0:15];
  logic       blog [0:15];

  uart_rx #(
    .CLK_RATE  (TB_CLK),
    .BAUD_RATE (TB_BAUD),
    .RESUME    (8'h00)
  ) dut (
    .CLK_I          (CLK_I),
    .RST_I          (RST_I),
    .RX_I           (RX_I),
    .DATA_O         (DATA_O),
    .RX_DONE_O      (RX_DONE_O),
    .RX_BUSY_O      (RX_BUSY_O),
    .FRAME_ERR_O    (FRAME_ERR_O),
    .PAUSE_O        (PAUSE_O),
    .ESC_DETECTED_O (ESC_DETECTED_O)
  );

  always #5 CLK_I = ~CLK_I;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge CLK_I) begin
    if (RX_DONE_O) begin
      if (n_done < 16) begin
        dlog[n_done] <= DATA_O;
        blog[n_done] <= RX_BUSY_O;
      end
      n_done <= n_done + 1;
    end
    if (FRAME_ERR_O)    n_ferr <= n_ferr + 1;
    if (ESC_DETECTED_O) n_esc  <= n_esc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge CLK_I);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    RX_I = 1'b0;
    wait_clks(BT);
    for (int i = 0; i < 8; i++) begin
      RX_I = b[i];
      wait_clks(BT);
    end
    RX_I = stop_bit;
    wait_clks(BT);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_data",  {24'h0, DATA_O}, 32'h00);
    chk("rst_done",  {31'h0, RX_DONE_O}, 32'h0);
    chk("rst_busy",  {31'h0, RX_BUSY_O}, 32'h0);
    chk("rst_ferr",  {31'h0, FRAME_ERR_O}, 32'h0);
    chk("rst_pause", {31'h0, PAUSE_O}, 32'h0);
    chk("rst_esc",   {31'h0, ESC_DETECTED_O}, 32'h0);
    wait_clks(3);
    RST_I = 1'b0;
    wait_clks(5);

    // Single good frame
    send_frame(8'h5A, 1'b1);
    wait_clks(4);
    chk("f5a_count", n_done, 1);
    chk("f5a_data",  {24'h0, DATA_O}, 32'h5A);
    chk("f5a_log",   {24'h0, dlog[0]}, 32'h5A);
    chk("f5a_busy",  {31'h0, blog[0]}, 32'h0);

    // Back-to-back frames, no idle gap
    send_frame(8'h01, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clks(4);
    chk("b2b_count", n_done, 3);
    chk("b2b_first", {24'h0, dlog[1]}, 32'h01);
    chk("b2b_second", {24'h0, dlog[2]}, 32'hFF);

    // Short low glitch on an idle line
    wait_clks(BT);
    RX_I = 1'b0;
    wait_clks(4);
    RX_I = 1'b1;
    wait_clks(2);
    chk("glitch_seen", {31'h0, RX_BUSY_O}, 32'h1);
    wait_clks(5);
    chk("glitch_idle", {31'h0, RX_BUSY_O}, 32'h0);
    wait_clks(BT);
    chk("glitch_nodone", n_done, 3);
    chk("glitch_noferr", n_ferr, 0);

    // Frame with low stop bit
    send_frame(8'h3C, 1'b0);
    RX_I = 1'b1;
    wait_clks(BT);
    chk("ferr_count", n_ferr, 1);
    chk("ferr_nodone", n_done, 3);
    chk("ferr_data", {24'h0, DATA_O}, 32'hFF);

    // Escape sequence ESC, 42, ESC, ESC, ESC, 00
    send_frame(TB_ESC, 1'b1);
    wait_clks(2);
    chk("esc1_pause", {31'h0, PAUSE_O}, 32'h1);
    chk("esc1_det",   n_esc, 1);
    chk("esc1_nodel", n_done, 3);
    send_frame(8'h42, 1'b1);
    wait_clks(2);
    chk("x42_pause", {31'h0, PAUSE_O}, 32'h1);
    send_frame(TB_ESC, 1'b1);
    send_frame(TB_ESC, 1'b1);
    send_frame(TB_ESC, 1'b1);
    wait_clks(2);
    chk("esc4_pause", {31'h0, PAUSE_O}, 32'h1);
    send_frame(8'h00, 1'b1);
    wait_clks(2);
    chk("res_pause",  {31'h0, PAUSE_O}, 32'h0);
    chk("esc_det_cnt", n_esc, 3);
    chk("esc_del_cnt", n_done, 5);
    chk("esc_del0", {24'h0, dlog[3]}, 32'h42);
    chk("esc_del1", {24'h0, dlog[4]}, {24'h0, TB_ESC});
    chk("esc_data", {24'h0, DATA_O}, {24'h0, TB_ESC});

    // Reset in the middle of data bit 4 of 0x99
    RX_I = 1'b0;
    wait_clks(BT);
    for (int i = 0; i < 4; i++) begin
      RX_I = ((8'h99 >> i) & 8'h01) != 8'h00;
      wait_clks(BT);
    end
    RX_I = 1'b1;
    wait_clks(BT / 2);
    RST_I = 1'b1;
    #1;
    chk("mrst_data",  {24'h0, DATA_O}, 32'h00);
    chk("mrst_busy",  {31'h0, RX_BUSY_O}, 32'h0);
    chk("mrst_pause", {31'h0, PAUSE_O}, 32'h0);
    chk("mrst_done",  {31'h0, RX_DONE_O}, 32'h0);
    wait_clks(3);
    RST_I = 1'b0;
    wait_clks(2 * BT);
    chk("mrst_nodone", n_done, 5);
    chk("mrst_noferr", n_ferr, 1);
    send_frame(8'h66, 1'b1);
    wait_clks(4);
    chk("post_count", n_done, 6);
    chk("post_data",  {24'h0, dlog[5]}, 32'h66);
    chk("post_busy",  {31'h0, RX_BUSY_O}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
